// File: rtl/fcs_append.sv
// CRC-32 (IEEE 802.3) FCS append stage: passes payload bytes through one output register
// and appends the four FCS bytes LSB first. Define FCS_APPEND_ASSERT_EN to compile in checks.
module fcs_append (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last
);

  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;

  typedef enum logic [0:0] {StData, StFcs} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;

  logic        load;
  logic        s_hs;
  logic [31:0] fcs;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign load    = ~m_valid_q | m_ready;
  assign s_ready = (state_q == StData) & load;
  assign s_hs    = s_valid & s_ready;
  assign fcs     = ~crc_q;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    unique case (state_q)
      StData: begin
        if (s_hs) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc_byte(crc_q, s_data);
          if (s_last) begin
            state_d = StFcs;
            cnt_d   = 2'd0;
          end
        end else if (load) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      StFcs: begin
        if (load) begin
          m_data_d  = fcs[{cnt_q, 3'b000} +: 8];
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q == 2'd3);
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StData;
            crc_d   = CrcInit;
            cnt_d   = 2'd0;
          end
        end
      end
      default: state_d = StData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StData;
      crc_q     <= CrcInit;
      cnt_q     <= 2'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

`ifdef FCS_APPEND_ASSERT_EN
  a_state_legal: assert property (@(posedge clk) disable iff (reset)
    (state_q == StData) || (state_q == StFcs))
    else $error("fcs_append: illegal state");

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (m_valid_q && !m_ready) |=> ($stable(m_valid_q) && $stable(m_data_q) && $stable(m_last_q)))
    else $error("fcs_append: output changed during stall");

  a_no_ready_in_fcs: assert property (@(posedge clk) disable iff (reset)
    (state_q == StFcs) |-> !s_ready)
    else $error("fcs_append: s_ready high while emitting FCS");

  // m_last can only be raised by the load of FCS byte 3.
  a_last_from_cnt3: assert property (@(posedge clk) disable iff (reset)
    $rose(m_last_q) |-> $past(state_q == StFcs && cnt_q == 2'd3 && load))
    else $error("fcs_append: m_last not from final FCS byte");
`endif

endmodule

// File: tb/tb_fcs_append.sv
// Randomized self-checking bench for fcs_append against a frame-level CRC-32 reference model.
module tb_fcs_append;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  fcs_append dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] src_q[$];   // {last, data} waiting to be offered
  logic [8:0] exp_q[$];   // {last, data} expected on the output
  logic [7:0] frame_q[$]; // payload of the frame being accepted
  logic [7:0] out_log[$];
  int         out_cyc[$];
  int         pending = 0;
  int         accepted = 0;
  int         cyc = 0;
  bit         rdy_rand = 0;
  bit         gap_rand = 0;
  bit         stall_chk = 0;
  logic [7:0] held_data;
  logic       held_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Whole-frame CRC-32 straight from the definition: reflected poly, init all ones, final invert.
  function automatic logic [31:0] frame_fcs(input logic [7:0] bytes[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        logic fb;
        fb = c[0] ^ bytes[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic cycle();
    logic load;
    logic [8:0] e;
    logic [31:0] f;
    @(negedge clk);
    if (stall_chk) begin
      check("stall_valid", {31'h0, m_valid}, 32'd1);
      check("stall_data", {24'h0, m_data}, {24'h0, held_data});
      check("stall_last", {31'h0, m_last}, {31'h0, held_last});
    end
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (src_q.size() > 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
      s_valid = 1'b1;
      {s_last, s_data} = src_q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
    end
    #1;
    load = !m_valid || m_ready;
    check("s_ready", {31'h0, s_ready}, {31'h0, (pending == 0) && load});
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'h0, m_data}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("m_data", {24'h0, m_data}, {24'h0, e[7:0]});
        check("m_last", {31'h0, m_last}, {31'h0, e[8]});
      end
      out_log.push_back(m_data);
      out_cyc.push_back(cyc);
    end
    stall_chk = m_valid && !m_ready;
    held_data = m_data;
    held_last = m_last;
    if (pending > 0 && load) pending--;
    if (s_valid && s_ready) begin
      void'(src_q.pop_front());
      accepted++;
      exp_q.push_back({1'b0, s_data});
      frame_q.push_back(s_data);
      if (s_last) begin
        f = frame_fcs(frame_q);
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, f[8*i +: 8]});
        frame_q.delete();
        pending = 4;
      end
    end
    cyc++;
  endtask

  task automatic push_frame(input logic [7:0] bytes[$]);
    foreach (bytes[k]) src_q.push_back({k == bytes.size() - 1, bytes[k]});
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic new_test();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic check_fcs_at(input string tag, input int idx, input logic [31:0] crc);
    if (out_log.size() < idx + 4) begin
      check({tag, "_len"}, out_log.size(), idx + 4);
    end else begin
      for (int i = 0; i < 4; i++) check(tag, {24'h0, out_log[idx + i]}, {24'h0, crc[8*i +: 8]});
    end
  endtask

  logic [7:0] abc[$];
  logic [7:0] one[$];
  logic [7:0] rnd[$];

  initial begin
    abc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one = '{8'h00};
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_m_valid", {31'h0, m_valid}, 32'd0);
    check("rst_m_last", {31'h0, m_last}, 32'd0);
    check("rst_m_data", {24'h0, m_data}, 32'd0);
    check("rst_s_ready", {31'h0, s_ready}, 32'd1);

    // "123456789", always ready
    new_test();
    push_frame(abc);
    run_idle(100);
    check("t1_beats", out_log.size(), 32'd13);
    check_fcs_at("t1_fcs", 9, 32'hCBF43926);
    if (out_cyc.size() == 13) check("t1_span", out_cyc[12] - out_cyc[0], 32'd12);

    // single zero byte
    new_test();
    push_frame(one);
    run_idle(100);
    check("t2_beats", out_log.size(), 32'd5);
    check_fcs_at("t2_fcs", 1, 32'hD202EF8D);

    // "123456789" with random backpressure
    new_test();
    rdy_rand = 1;
    push_frame(abc);
    run_idle(200);
    rdy_rand = 0;
    check("t3_beats", out_log.size(), 32'd13);
    check_fcs_at("t3_fcs", 9, 32'hCBF43926);

    // back-to-back frames, no bubble
    new_test();
    push_frame(abc);
    push_frame(one);
    run_idle(200);
    check("t4_beats", out_log.size(), 32'd18);
    check_fcs_at("t4_fcs_a", 9, 32'hCBF43926);
    check_fcs_at("t4_fcs_b", 14, 32'hD202EF8D);
    if (out_cyc.size() == 18) check("t4_span", out_cyc[17] - out_cyc[0], 32'd17);

    // reset after 5 accepted bytes
    new_test();
    accepted = 0;
    push_frame(abc);
    for (int n = 0; n < 50 && accepted < 5; n++) cycle();
    check("t5_accepted", accepted, 32'd5);
    src_q.delete();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_m_valid", {31'h0, m_valid}, 32'd0);
    check("t5_s_ready", {31'h0, s_ready}, 32'd1);
    check("t5_m_last", {31'h0, m_last}, 32'd0);
    exp_q.delete(); frame_q.delete(); pending = 0; stall_chk = 0;
    new_test();
    push_frame(abc);
    run_idle(100);
    check("t5_beats", out_log.size(), 32'd13);
    check_fcs_at("t5_fcs", 9, 32'hCBF43926);

    // random frames, random gaps and backpressure
    rdy_rand = 1;
    gap_rand = 1;
    for (int f = 0; f < 20; f++) begin
      rnd.delete();
      for (int i = 0; i < $urandom_range(1, 20); i++) rnd.push_back(8'($urandom));
      push_frame(rnd);
    end
    run_idle(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fcs_append.md
# fcs_append

Transmit-path framing stage that computes the IEEE 802.3 / 802.11 CRC-32 frame check sequence over a byte stream and appends the four FCS bytes after the last payload byte. It sits directly upstream of the transmit sample FIFO (`memory`, WIDTH=8) and feeds it through the common valid/ready handshake. It has one output register stage and stalls the source while it emits the FCS.

## Interface
- No parameters. Data width is fixed at 8 bits.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: input byte accepted when `s_valid & s_ready`.
- `s_data` in 8: payload byte.
- `s_last` in 1: marks the final payload byte of a frame.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: downstream accept.
- `m_data` out 8: payload or FCS byte.
- `m_last` out 1: asserted only with the final FCS byte.

## Operation
- States: `DATA`, `FCS`.
- Reset values:
  - `m_valid=0`, `m_last=0`, `m_data=0`.
  - State `DATA`, CRC register `32'hFFFFFFFF`, FCS byte counter `0`.
- `s_ready = (state==DATA) & (~m_valid | m_ready)`. This is combinational, and is the only comb path from `m_ready`.
- Load condition for the output register: `load = ~m_valid | m_ready`.
- CRC definition:
  - Reflected polynomial `32'hEDB88320`, bits processed LSB first.
  - Init `FFFFFFFF`.
  - One byte per accepted input, computed with 8 unrolled bit steps in one cycle.
- In `DATA`, on each input handshake:
  - `m_data<=s_data`, `m_valid<=1`, `m_last<=0`.
  - CRC is updated with `s_data`.
  - If `s_last`, go to `FCS` with counter `0`.
- In `DATA` with no handshake: if `load`, then `m_valid<=0`.
- In `FCS`:
  - FCS value is `~crc`.
  - On each `load`: `m_data <= fcs[8*cnt +: 8]` (least-significant byte first), `m_valid<=1`, and `m_last<=(cnt==3)`.
  - The counter increments on each such load.
  - After the cnt==3 load: return to `DATA`, CRC reinitialised to `FFFFFFFF`, counter to `0`.
- `s_last` is consumed internally and never forwarded on payload bytes.
- Single-byte frames are legal. Zero-length frames cannot be expressed.
- `s_data` and `s_last` are ignored when there is no handshake.
- Reset mid-frame:
  - The partial frame is discarded. No FCS is emitted.
  - All outputs return to their reset values on the next edge.
  - Any held output byte is dropped.

## Timing
- Latency: an accepted input byte appears on `m_data` one cycle later.
- Throughput:
  - 1 byte/cycle with `m_ready` held high.
  - Frame of N payload bytes occupies N+4 output beats.
  - `s_ready` is low for exactly 4 output handshakes after `s_last` is accepted.
- Stall: while `m_valid & ~m_ready`, `m_data`/`m_last`/`m_valid` hold. CRC, counter and state do not change.
- Back-to-back frames:
  - `s_ready` rises in the same cycle the cnt==3 byte is registered.
  - With `s_valid` and `m_ready` held high, the next frame's first byte is accepted in the cycle after that edge, with no bubble.
- `m_valid` never depends combinationally on any input.

## Configuration
- `FCS_APPEND_ASSERT_EN` defined:
  - Concurrent assertions are compiled in, checking the following:
    - State is always `DATA` or `FCS`.
    - `m_valid`/`m_data`/`m_last` are stable during a stall.
    - `s_ready==0` in `FCS`.
    - `m_last` is seen only with cnt==3 data.
  - Each violation raises `$error`.
- Not defined: no assertion logic is compiled in. RTL behaviour is identical either way.

## Test plan
- Frame ASCII "123456789" (`31..39`), `m_ready=1`: output is `31..39, 26 39 F4 CB`, `m_last` only on `CB`, total 13 beats.
- Single byte `00` with `s_last`: output is `00, 8D EF 02 D2` (CRC `D202EF8D`), `s_ready` low for 4 cycles.
- "123456789" with `m_ready` toggling on a pseudo-random 50% pattern: same 13-byte sequence, no drops or duplicates, outputs stable during stalls.
- Two back-to-back frames, "123456789" then `00`: both FCS values are correct (CRC reinitialised), with no idle beat between frames.
- `reset` asserted after 5 bytes of "123456789":
  - The cycle after reset: `m_valid=0`, `s_ready=1`.
  - A subsequent full "123456789" frame produces `CB F4 39 26` reversed correctly (i.e. `26 39 F4 CB`).
- With the assert macro defined, run all the above: zero assertion failures.
